// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that writes HI/LO, with mthi/mtlo writes and a registered Busy.
// Define MDU_MADD_EN to add madd/maddu (64-bit accumulate into {HI,LO}).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MDA,
  input  logic [31:0] MDB,
  input  logic [2:0]  MDOp,
  input  logic        Start,
  input  logic        HIWe,
  input  logic        LOWe,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [31:0]     a_r, b_r;
  logic [2:0]      op_r;
  logic [31:0]     hi_r, lo_r;
  logic            busy_r;

  logic            legal_s, start_div_s;
  logic            is_div_s, is_signed_s;
  logic [63:0]     mul_a_s, mul_b_s, prod_s;
  logic [31:0]     ua_s, ub_s, uq_s, ur_s;
  logic [31:0]     res_hi_s, res_lo_s;
  logic            res_we_s;

  // Decode which incoming requests may start an operation.
  always_comb begin
    legal_s     = 1'b0;
    start_div_s = (MDOp[2:1] == 2'b01);
`ifdef MDU_MADD_EN
    if (MDOp <= 3'd5) begin
      legal_s = 1'b1;
    end else begin
      legal_s = 1'b0;
    end
`else
    if (MDOp <= 3'd3) begin
      legal_s = 1'b1;
    end else begin
      legal_s = 1'b0;
    end
`endif
  end

  // Result datapath from the captured operands; one shared multiplier and one unsigned divider.
  always_comb begin
    is_div_s    = (op_r[2:1] == 2'b01);
    is_signed_s = ~op_r[0];
    mul_a_s     = is_signed_s ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
    mul_b_s     = is_signed_s ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
    prod_s      = mul_a_s * mul_b_s;
    // Signed division runs on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
    ua_s = (is_signed_s && a_r[31]) ? (32'd0 - a_r) : a_r;
    ub_s = (is_signed_s && b_r[31]) ? (32'd0 - b_r) : b_r;
    if (ub_s == 32'd0) begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end else begin
      uq_s = ua_s / ub_s;
      ur_s = ua_s % ub_s;
    end
    res_we_s = 1'b1;
    res_hi_s = prod_s[63:32];
    res_lo_s = prod_s[31:0];
    if (is_div_s) begin
      res_we_s = (b_r != 32'd0);
      res_lo_s = (is_signed_s && (a_r[31] ^ b_r[31])) ? (32'd0 - uq_s) : uq_s;
      res_hi_s = (is_signed_s && a_r[31]) ? (32'd0 - ur_s) : ur_s;
    end else begin
`ifdef MDU_MADD_EN
      if (op_r[2]) begin
        {res_hi_s, res_lo_s} = {hi_r, lo_r} + prod_s;
      end else begin
        {res_hi_s, res_lo_s} = prod_s;
      end
`else
      {res_hi_s, res_lo_s} = prod_s;
`endif
    end
  end

  // Control FSM, operand capture and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      op_r    <= 3'd0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start && legal_s) begin
            a_r     <= MDA;
            b_r     <= MDB;
            op_r    <= MDOp;
            cnt_r   <= start_div_s ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_r <= RUN;
            busy_r  <= 1'b1;
          end else if (!Start) begin
            if (HIWe) hi_r <= MDA;
            if (LOWe) lo_r <= MDA;
          end
        end
        RUN: begin
          if (cnt_r == CW'(1)) begin
            if (res_we_s) begin
              hi_r <= res_hi_s;
              lo_r <= res_lo_s;
            end
            cnt_r   <= '0;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops against a
// plain-arithmetic HI/LO model. Follows MDU_MADD_EN when it is defined.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] MDA = 32'd0, MDB = 32'd0;
  logic [2:0]  MDOp = 3'd0;
  logic        Start = 1'b0, HIWe = 1'b0, LOWe = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDA(MDA), .MDB(MDB), .MDOp(MDOp),
    .Start(Start), .HIWe(HIWe), .LOWe(LOWe), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return MC;
      3'd2, 3'd3: return DC;
`ifdef MDU_MADD_EN
      3'd4, 3'd5: return MC;
`endif
      default:    return 0;
    endcase
  endfunction

  // Reference: what HI/LO should hold after the op completes.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    longint sp, q, r;
    logic [63:0] up, acc;
    sa = int'(a);
    sb = int'(b);
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    acc = {m_hi, m_lo};
    if (lat(op) == 0) return;
    case (op)
      3'd0: {m_hi, m_lo} = sp;
      3'd1: {m_hi, m_lo} = up;
      3'd2: if (b != 32'd0) begin
              q = longint'(sa) / longint'(sb);
              r = longint'(sa) % longint'(sb);
              m_lo = q[31:0];
              m_hi = r[31:0];
            end
      3'd3: if (b != 32'd0) begin
              m_lo = a / b;
              m_hi = a % b;
            end
      3'd4: {m_hi, m_lo} = acc + 64'(sp);
      3'd5: {m_hi, m_lo} = acc + up;
      default: ;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic wlo);
    logic [31:0] old_hi, old_lo;
    int n;
    old_hi = m_hi;
    old_lo = m_lo;
    @(negedge clk);
    MDOp = op; MDA = a; MDB = b; Start = 1'b1; LOWe = wlo; HIWe = 1'b0;
    model_apply(op, a, b);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!Busy) break;
      n++;
      chk({tag, "_hi_stable"}, HI, old_hi);
      chk({tag, "_lo_stable"}, LO, old_lo);
      // Noise while busy: must all be ignored.
      Start = $urandom_range(0, 1) == 1;
      MDOp  = 3'($urandom_range(0, 7));
      MDA   = $urandom;
      MDB   = $urandom;
      HIWe  = $urandom_range(0, 1) == 1;
      LOWe  = $urandom_range(0, 1) == 1;
    end
    Start = 1'b0; HIWe = 1'b0; LOWe = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'(lat(op)));
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  task automatic mt(input string tag, input logic hw, input logic lw, input logic [31:0] v);
    @(negedge clk);
    MDA = v; HIWe = hw; LOWe = lw; Start = 1'b0;
    if (hw) m_hi = v;
    if (lw) m_lo = v;
    @(negedge clk);
    HIWe = 1'b0; LOWe = 1'b0;
    chk({tag, "_hi"}, HI, m_hi);
    chk({tag, "_lo"}, LO, m_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_hi", HI, 32'd0);
    chk("reset_lo", LO, 32'd0);
    reset = 1'b0;

    run_op("mult_neg1x2", 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("mult_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_lo_const", LO, 32'hFFFF_FFFE);
    run_op("multu_max2", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi_const", HI, 32'h0000_0001);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo_const", LO, 32'hFFFF_FFFD);
    chk("div_hi_const", HI, 32'hFFFF_FFFF);
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 1'b0);
    run_op("div_minint", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_minint_lo_const", LO, 32'h8000_0000);

    mt("mthi", 1'b1, 1'b0, 32'h1234_5678);
    chk("mthi_const", HI, 32'h1234_5678);
    mt("mtlo", 1'b0, 1'b1, 32'hCAFE_0001);
    mt("mthilo", 1'b1, 1'b1, 32'hA5A5_5A5A);
    run_op("start_lowe", 3'd1, 32'd3, 32'd5, 1'b1);
    chk("start_lowe_lo_const", LO, 32'd15);
    run_op("illegal_op", 3'd7, 32'd9, 32'd9, 1'b0);

    // Asynchronous reset three cycles into a divide.
    run_op("pre_reset", 3'd1, 32'h0001_0000, 32'h0001_0003, 1'b0);
    @(negedge clk);
    MDOp = 3'd2; MDA = 32'd100; MDB = 32'd7; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midreset_busy", Busy, 1'b0);
    chk("midreset_hi", HI, 32'd0);
    chk("midreset_lo", LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    run_op("post_reset_div", 3'd2, 32'd100, 32'd7, 1'b0);

    mt("madd_prep", 1'b1, 1'b1, 32'd0);
    mt("madd_prep_lo", 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op("madd_1x1", 3'd4, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
    chk("madd_hi_const", HI, 32'd1);
    chk("madd_lo_const", LO, 32'd0);
`else
    chk("madd_off_hi_const", HI, 32'd0);
    chk("madd_off_lo_const", LO, 32'hFFFF_FFFF);
`endif

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        mt("rnd_mt", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      end else begin
        op = 3'($urandom_range(0, 7));
        a  = pick();
        b  = pick();
        run_op("rnd_op", op, a, b, (lat(op) != 0) && ($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
